keystream_scheduler: RTL and testbench
======================================

// Module: keystream_scheduler
// PURPOSE
//  Sequences the hash generator on behalf of the encryption block. It prefetches keystream
//  bytes into a DEPTH-entry FIFO, so an encrypt request is normally served in 1 cycle.
//  It flushes the FIFO and restarts the generator on a hash reset or a key reload.
//  Sits between reader/key_storage (flush sources), hash_generator and encryption_block.
// PARAMETERS
//  DEPTH    4   keystream FIFO entries; power of 2, >=2
//  TIMEOUT  15  max cycles waiting for hash_byte_pulse after a request; >=2
// PORTS
//  clk               in   1   clock, all logic on rising edge
//  rst               in   1   asynchronous, active-high reset
//  reset_hash_pulse  in   1   1-cycle: user hash reset (from reader)
//  key_loaded_pulse  in   1   1-cycle: key_storage accepted a key byte
//  gen_ready         in   1   hash generator idle, may accept a request
//  hash_req_pulse    out  1   1-cycle request for one keystream byte
//  hash_byte         in   8   keystream byte, valid with hash_byte_pulse
//  hash_byte_pulse   in   1   1-cycle: hash_byte valid
//  hash_reset_out    out  1   1-cycle: restart hash generator
//  ks_req_pulse      in   1   1-cycle: encryption block wants a byte
//  ks_byte           out  8   keystream byte to encryption block
//  ks_byte_pulse     out  1   1-cycle: ks_byte valid
//  fifo_count        out  $clog2(DEPTH+1)  bytes held
//  state_out         out  2   0 IDLE, 1 WAIT, 2 FLUSH
//  err               out  2   sticky: [0] timeout, [1] request overrun
// BEHAVIOUR
//  - Reset: FIFO empty, fifo_count=0, state IDLE, timer=0, pending=0, err=0.
//    All pulse outputs are 0 and ks_byte=0. All outputs are registered.
//  - FLUSH trigger: reset_hash_pulse | key_loaded_pulse, in any state. It has priority over
//    everything except rst.
//    Next cycle: FIFO cleared, count=0, timer=0, hash_reset_out=1 for exactly 1 cycle,
//    state=FLUSH. FLUSH lasts 1 cycle, then IDLE.
//    A trigger arriving while in FLUSH re-enters FLUSH and re-pulses hash_reset_out.
//  - IDLE: if gen_ready and fifo_count<DEPTH, assert hash_req_pulse for 1 cycle, then go to
//    WAIT with timer=0. Otherwise stay in IDLE.
//  - WAIT: timer increments each cycle.
//    On hash_byte_pulse, push hash_byte and return to IDLE.
//    When timer==TIMEOUT without a response: set err[0] and return to IDLE (request retried).
//  - hash_byte_pulse outside WAIT is ignored, including a stale byte during or after FLUSH.
//  - Consumer: on ks_req_pulse with fifo_count>0 at that edge, the next cycle gives
//    ks_byte=head and ks_byte_pulse=1, and the head is popped.
//    Latency is exactly 1 cycle.
//  - Empty FIFO: ks_req_pulse sets pending=1. The byte is served on the first cycle with
//    fifo_count>0, which is the cycle after the push; there is no bypass.
//    ks_req_pulse while pending=1 sets err[1] and is dropped.
//  - pending survives FLUSH, and is served from the new stream.
//    A ks_req_pulse in the same cycle as a flush trigger is recorded as pending.
//  - Simultaneous push and pop: both occur and count is unchanged.
//    A push when full cannot happen, because a request is issued only when count<DEPTH.
//  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count saturates at
//    0..DEPTH.
//  - ks_byte holds its last value between pulses. It is cleared only by rst.
//  - rst asserted mid-operation: immediate return to the reset state. No hash_reset_out is
//    generated by rst alone.
// TESTING
//  1. Prefill: rst, then gen_ready=1 and the generator answers 2 cycles after each
//     request with 0x11,0x22,... -> 4 requests, fifo_count=4, then hash_req_pulse stays 0.
//  2. Hit: FIFO full, ks_req_pulse -> next cycle ks_byte=0x11 and ks_byte_pulse=1,
//     fifo_count=3, and a refill request follows.
//  3. Miss: FIFO empty, gen_ready=0, ks_req_pulse -> no ks_byte_pulse.
//     Then gen_ready=1 and the byte 0xA5 arrives -> ks_byte=0xA5 one cycle after the push.
//     A second ks_req during the wait sets err[1].
//  4. Flush: FIFO holds 3 bytes, reset_hash_pulse -> next cycle fifo_count=0,
//     hash_reset_out=1 for 1 cycle, state=FLUSH then IDLE.
//     A stale hash_byte_pulse during FLUSH does not change fifo_count.
//  5. Timeout: the generator never answers -> after 15 cycles in WAIT, err[0]=1 and a new
//     hash_req_pulse is issued.
//  6. Async reset in WAIT with pending=1 -> outputs are reset values before the next clock
//     edge; err=0.

Source files
------------

// File: rtl/keystream_scheduler_if.sv
// Handshake bundle between the keystream scheduler, its flush sources, the hash
// generator and the encryption block. master = scheduler side, slave = environment.
interface keystream_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          reset_hash_pulse;
  logic          key_loaded_pulse;
  logic          gen_ready;
  logic          hash_req_pulse;
  logic [7:0]    hash_byte;
  logic          hash_byte_pulse;
  logic          hash_reset_out;
  logic          ks_req_pulse;
  logic [7:0]    ks_byte;
  logic          ks_byte_pulse;
  logic [CW-1:0] fifo_count;
  logic [1:0]    state_out;
  logic [1:0]    err;

  modport master (
    input  reset_hash_pulse, key_loaded_pulse, gen_ready, hash_byte, hash_byte_pulse,
           ks_req_pulse,
    output hash_req_pulse, hash_reset_out, ks_byte, ks_byte_pulse, fifo_count, state_out, err
  );

  modport slave (
    output reset_hash_pulse, key_loaded_pulse, gen_ready, hash_byte, hash_byte_pulse,
           ks_req_pulse,
    input  hash_req_pulse, hash_reset_out, ks_byte, ks_byte_pulse, fifo_count, state_out, err
  );
endinterface

// File: rtl/keystream_scheduler.sv
// Prefetches keystream bytes from the hash generator into a small FIFO and serves the
// encryption block with 1-cycle latency; flushes and restarts the generator on key/hash reset.
module keystream_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  keystream_scheduler_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_reg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [TW-1:0] timer_reg;
  logic          pending_reg;
  logic [1:0]    err_reg;
  logic          hash_req_reg;
  logic          hash_reset_reg;
  logic [7:0]    ks_byte_reg;
  logic          ks_pulse_reg;

  logic flush;
  logic push;
  logic pop;

  // A flush outranks both the producer and the consumer side in the same cycle.
  assign flush = bus.reset_hash_pulse | bus.key_loaded_pulse;
  assign push  = !flush && (state_reg == WAIT) && bus.hash_byte_pulse;
  assign pop   = !flush && (count_reg != '0) && (pending_reg || bus.ks_req_pulse);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.hash_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      timer_reg      <= '0;
      pending_reg    <= 1'b0;
      err_reg        <= 2'b00;
      hash_req_reg   <= 1'b0;
      hash_reset_reg <= 1'b0;
      ks_byte_reg    <= 8'h00;
      ks_pulse_reg   <= 1'b0;
    end else begin
      hash_req_reg   <= 1'b0;
      hash_reset_reg <= flush;
      ks_pulse_reg   <= pop;

      if (flush) begin
        state_reg  <= FLUSH;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        timer_reg  <= '0;
        // Pending requests survive the flush and are served from the new stream.
        if (bus.ks_req_pulse) begin
          if (pending_reg) begin
            err_reg[1] <= 1'b1;
          end else begin
            pending_reg <= 1'b1;
          end
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.gen_ready && (count_reg < CW'(DEPTH))) begin
              hash_req_reg <= 1'b1;
              state_reg    <= WAIT;
              timer_reg    <= '0;
            end
          end
          WAIT: begin
            if (bus.hash_byte_pulse) begin
              state_reg <= IDLE;
            end else if (timer_reg == TW'(TIMEOUT)) begin
              err_reg[0] <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase

        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg  <= rd_ptr_reg + 1'b1;
          ks_byte_reg <= mem[rd_ptr_reg];
        end
        if (push && !pop && (count_reg != CW'(DEPTH))) begin
          count_reg <= count_reg + 1'b1;
        end else if (pop && !push) begin
          count_reg <= count_reg - 1'b1;
        end

        // A pop always serves the pending request first; a new request on top is dropped.
        if (bus.ks_req_pulse && pending_reg) begin
          err_reg[1] <= 1'b1;
        end
        if (pop) begin
          pending_reg <= 1'b0;
        end else if (bus.ks_req_pulse && (count_reg == '0)) begin
          pending_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.hash_req_pulse = hash_req_reg;
  assign bus.hash_reset_out = hash_reset_reg;
  assign bus.ks_byte        = ks_byte_reg;
  assign bus.ks_byte_pulse  = ks_pulse_reg;
  assign bus.fifo_count     = count_reg;
  assign bus.state_out      = state_reg;
  assign bus.err            = err_reg;
endmodule

// File: tb/tb_keystream_scheduler.sv
// Directed bench for keystream_scheduler: prefill, hit, miss, flush, timeout, async reset.
module tb_keystream_scheduler;
  logic clk;
  logic rst;

  keystream_scheduler_if #(.DEPTH(4)) bus ();

  keystream_scheduler #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  int   req_cnt;
  int   ks_cnt;
  int   resp_cnt;
  bit   gen_auto;
  logic [7:0] next_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One clock: drop single-cycle pulses after the edge and model a generator that
  // answers two cycles after each request.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.ks_req_pulse     = 1'b0;
    bus.reset_hash_pulse = 1'b0;
    bus.key_loaded_pulse = 1'b0;
    bus.hash_byte_pulse  = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.hash_byte_pulse = 1'b1;
        bus.hash_byte       = next_byte;
        next_byte           = next_byte + 8'h11;
      end
    end
    if (bus.hash_req_pulse) begin
      req_cnt++;
      if (gen_auto) resp_cnt = 1;
    end
    if (bus.ks_byte_pulse) ks_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int push_at;
    int pulse_at;
    int base;
    bit seen;
    logic [7:0] exp_b;

    checks = 0; errors = 0; req_cnt = 0; ks_cnt = 0; resp_cnt = 0;
    gen_auto = 1'b0; next_byte = 8'h11;
    rst = 1'b1;
    bus.reset_hash_pulse = 1'b0; bus.key_loaded_pulse = 1'b0; bus.gen_ready = 1'b0;
    bus.hash_byte = 8'h00; bus.hash_byte_pulse = 1'b0; bus.ks_req_pulse = 1'b0;
    ticks(3);

    check("rst_count", 32'(bus.fifo_count), 0);
    check("rst_state", 32'(bus.state_out), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_req", 32'(bus.hash_req_pulse), 0);
    check("rst_hreset", 32'(bus.hash_reset_out), 0);
    check("rst_ksbyte", 32'(bus.ks_byte), 0);
    check("rst_kspulse", 32'(bus.ks_byte_pulse), 0);

    // 1. Prefill
    rst = 1'b0; bus.gen_ready = 1'b1; gen_auto = 1'b1;
    ticks(25);
    check("prefill_reqs", 32'(req_cnt), 4);
    check("prefill_count", 32'(bus.fifo_count), 4);
    ticks(5);
    check("prefill_no_more_req", 32'(req_cnt), 4);

    // 2. Hit
    bus.ks_req_pulse = 1'b1;
    tick();
    check("hit_pulse", 32'(bus.ks_byte_pulse), 1);
    check("hit_byte", 32'(bus.ks_byte), 32'h11);
    check("hit_count", 32'(bus.fifo_count), 3);
    tick();
    check("hit_refill_req", 32'(bus.hash_req_pulse), 1);
    check("hit_byte_hold", 32'(bus.ks_byte), 32'h11);
    check("hit_pulse_drop", 32'(bus.ks_byte_pulse), 0);
    ticks(5);
    check("hit_refilled", 32'(bus.fifo_count), 4);

    // 3. Miss: drain, then request from an empty FIFO
    bus.gen_ready = 1'b0;
    exp_b = 8'h22;
    for (int i = 0; i < 4; i++) begin
      bus.ks_req_pulse = 1'b1;
      tick();
      check($sformatf("drain%0d_byte", i), 32'(bus.ks_byte), 32'(exp_b));
      exp_b = exp_b + 8'h11;
    end
    check("drain_count", 32'(bus.fifo_count), 0);
    base = ks_cnt;
    bus.ks_req_pulse = 1'b1;
    tick();
    check("miss_no_pulse", 32'(bus.ks_byte_pulse), 0);
    ticks(2);
    bus.ks_req_pulse = 1'b1;
    tick();
    check("miss_overrun_err", 32'(bus.err), 32'b10);
    check("miss_no_pulse_yet", 32'(ks_cnt - base), 0);
    next_byte = 8'hA5; bus.gen_ready = 1'b1;
    push_at = -1; pulse_at = -1;
    for (int i = 0; i < 20 && pulse_at < 0; i++) begin
      tick();
      if (push_at < 0 && bus.fifo_count != 0) push_at = i;
      if (bus.ks_byte_pulse) pulse_at = i;
    end
    check("miss_served", 32'(pulse_at >= 0), 1);
    check("miss_byte", 32'(bus.ks_byte), 32'hA5);
    check("miss_latency", 32'(pulse_at - push_at), 1);

    // Refill to full, then pop one to leave three
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.fifo_count == 4 && bus.state_out == 0) seen = 1'b1;
    end
    check("refill_full", 32'(seen), 1);
    bus.gen_ready = 1'b0;
    bus.ks_req_pulse = 1'b1;
    tick();
    check("pop_b6", 32'(bus.ks_byte), 32'hB6);
    check("three_left", 32'(bus.fifo_count), 3);

    // 4. Flush, with a stale byte arriving during FLUSH
    bus.reset_hash_pulse = 1'b1;
    tick();
    check("flush_count", 32'(bus.fifo_count), 0);
    check("flush_hreset", 32'(bus.hash_reset_out), 1);
    check("flush_state", 32'(bus.state_out), 2);
    bus.hash_byte_pulse = 1'b1; bus.hash_byte = 8'hEE;
    tick();
    check("flush_done_state", 32'(bus.state_out), 0);
    check("flush_hreset_drop", 32'(bus.hash_reset_out), 0);
    check("flush_stale_ignored", 32'(bus.fifo_count), 0);
    bus.key_loaded_pulse = 1'b1;
    tick();
    check("keyload_hreset", 32'(bus.hash_reset_out), 1);
    check("keyload_state", 32'(bus.state_out), 2);
    tick();

    // 5. Timeout: generator never answers
    gen_auto = 1'b0; bus.gen_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.err[0]) seen = 1'b1;
    end
    check("timeout_err", 32'(bus.err), 32'b11);
    tick();
    check("timeout_retry_req", 32'(bus.hash_req_pulse), 1);

    // 6. Async reset in WAIT with a pending request
    bus.ks_req_pulse = 1'b1;
    tick();
    check("pre_rst_state", 32'(bus.state_out), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_err", 32'(bus.err), 0);
    check("arst_state", 32'(bus.state_out), 0);
    check("arst_count", 32'(bus.fifo_count), 0);
    check("arst_hreset", 32'(bus.hash_reset_out), 0);
    check("arst_ksbyte", 32'(bus.ks_byte), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    gen_auto = 1'b1; resp_cnt = 0;
    base = ks_cnt;
    ticks(10);
    check("arst_pending_cleared", 32'(ks_cnt - base), 0);
    check("arst_refill", 32'(bus.fifo_count != 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
